div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter DZ_Q, default 8'hFF: quotient value returned on divide-by-zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  requester offers an operand pair.
REQ-005 in_ready  output  1  controller can accept; high only in IDLE.
REQ-006 n  input  16  dividend, sampled on accept.
REQ-007 d  input  8  divisor, sampled on accept.
REQ-008 out_valid  output  1  result valid; high only in DONE.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 q  output  8  quotient.
REQ-011 r  output  8  remainder.
REQ-012 dz  output  1  divide-by-zero flag, qualified by out_valid.
REQ-013 ovf  output  1  quotient-overflow flag, qualified by out_valid; tied 0 without DIV_SEQ_OVF_CHK_EN.
REQ-014 busy  output  1  high in CALC.

Function
REQ-015 States IDLE, CALC, DONE; accept = in_valid && in_ready, on a rising edge in IDLE.
REQ-016 Accept latches n, d; initial partial remainder rem (9 bit) = {1'b0, n[15:8]}; 3-bit step counter = 7.
REQ-017 Accept with d == 0: go to DONE; q = DZ_Q, r = n[7:0], dz = 1, no CALC cycles.
REQ-018 Otherwise go to CALC; each CALC cycle handles bit i = counter: t = {rem[7:0], n[i]}; if t >= d then rem = t - d, q[i] = 1, else rem = t, q[i] = 0.
REQ-019 Restoring iteration only, one quotient bit per cycle, MSB first; exactly 8 CALC cycles.
REQ-020 After counter 0 is processed: go to DONE; r = rem[7:0], dz = 0.
REQ-021 Latency: normal path out_valid high 9 rising edges after accept edge; dz/ovf short path 1 edge after.
REQ-022 DONE: q, r, dz, ovf held stable while out_valid && !out_ready; on out_valid && out_ready go to IDLE.
REQ-023 No overlap: in_ready = 0 in CALC and DONE; earliest next accept is the edge after the handshake edge.
REQ-024 in_valid, n, d changes during CALC/DONE are ignored.
REQ-025 Result for d != 0 and n[15:8] < d equals floor(n/d), n mod d exactly.
REQ-026 Without overflow check, n[15:8] >= d runs the same 8 steps; t MSB beyond 9 bits is dropped; result defined by REQ-018 only.

Reset
REQ-027 rst_n low asynchronously forces IDLE; in_ready = 1, out_valid = 0, busy = 0, q = 0, r = 0, dz = 0, ovf = 0, counter = 0.
REQ-028 Reset during CALC or DONE discards the operation; no result is ever presented for it.
REQ-029 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro DIV_SEQ_OVF_CHK_EN defined: accept with d != 0 and n[15:8] >= d goes to DONE on the next edge with q = 8'hFF, r = 8'hFF, ovf = 1, dz = 0; no CALC.
REQ-031 Macro DIV_SEQ_OVF_CHK_EN undefined: no comparison logic; ovf constant 0; such operands follow REQ-026.
REQ-032 d == 0 takes priority over overflow (dz = 1, ovf = 0).

Verification
REQ-033 n=16'h1234, d=8'h56, out_ready=1 -> after 9 edges q=8'h36, r=8'h10, dz=0, ovf=0.
REQ-034 n=16'h00FF, d=8'h01 -> q=8'hFF, r=8'h00; busy high exactly 8 cycles.
REQ-035 n=16'hABCD, d=8'h00 -> next edge out_valid, q=DZ_Q, r=8'hCD, dz=1.
REQ-036 n=16'h0100, d=8'h01 -> with macro: 1-edge latency, q=8'hFF, r=8'hFF, ovf=1; without: q=8'hFF, r=8'h01, ovf=0.
REQ-037 Hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> q/r stable, in_ready=0; release -> IDLE, next op accepted.
REQ-038 Assert rst_n=0 at CALC step 4 -> out_valid/busy drop immediately, in_ready=1; new op after release yields correct result.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequential 16/8 restoring divider controller: valid/ready in, valid/ready out, one quotient bit per cycle.
// Optional quotient-overflow short path enabled by defining DIV_SEQ_OVF_CHK_EN.
module div_seq_ctrl #(
    parameter logic [7:0] DZ_Q = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] n,
    input  logic [7:0]  d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        dz,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  n_lo_reg;
    logic [7:0]  d_reg;
    logic [7:0]  rem_reg;
    logic [2:0]  cnt_reg;
    logic [7:0]  q_reg;
    logic [7:0]  r_reg;
    logic        dz_reg;
`ifdef DIV_SEQ_OVF_CHK_EN
    logic        ovf_reg;
`endif

    // Partial remainder only keeps 8 bits; the shifted-out MSB lives in t[8] for the compare.
    logic [8:0]  t;
    logic        take;
    logic [7:0]  diff;
    logic [7:0]  rem_next;

    assign t        = {rem_reg, n_lo_reg[cnt_reg]};
    assign take     = (t >= {1'b0, d_reg});
    assign diff     = t[7:0] - d_reg;
    assign rem_next = take ? diff : t[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            n_lo_reg  <= 8'h00;
            d_reg     <= 8'h00;
            rem_reg   <= 8'h00;
            cnt_reg   <= 3'd0;
            q_reg     <= 8'h00;
            r_reg     <= 8'h00;
            dz_reg    <= 1'b0;
`ifdef DIV_SEQ_OVF_CHK_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        n_lo_reg <= n[7:0];
                        d_reg    <= d;
                        rem_reg  <= n[15:8];
                        cnt_reg  <= 3'd7;
                        q_reg    <= 8'h00;
                        dz_reg   <= 1'b0;
`ifdef DIV_SEQ_OVF_CHK_EN
                        ovf_reg  <= 1'b0;
`endif
                        // Divide-by-zero wins over the overflow check.
                        if (d == 8'h00) begin
                            q_reg     <= DZ_Q;
                            r_reg     <= n[7:0];
                            dz_reg    <= 1'b1;
                            state_reg <= DONE;
                        end
`ifdef DIV_SEQ_OVF_CHK_EN
                        else if (n[15:8] >= d) begin
                            q_reg     <= 8'hFF;
                            r_reg     <= 8'hFF;
                            ovf_reg   <= 1'b1;
                            state_reg <= DONE;
                        end
`endif
                        else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg        <= rem_next;
                    q_reg[cnt_reg] <= take;
                    if (cnt_reg == 3'd0) begin
                        r_reg     <= rem_next;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == CALC);
    assign q         = q_reg;
    assign r         = r_reg;
    assign dz        = dz_reg;
`ifdef DIV_SEQ_OVF_CHK_EN
    assign ovf       = ovf_reg;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: hand-computed vectors, latency, hold and reset-abort checks.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int edges;
    int busy_cnt;

    div_seq_ctrl #(.DZ_Q(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer an operand pair at the falling edge; returns 1 ns after the accept edge.
    task automatic start(input logic [15:0] nn, input logic [7:0] dd);
        @(negedge clk);
        in_valid = 1'b1;
        n        = nn;
        d        = dd;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid; bounded.
    task automatic wait_done();
        edges    = 1;
        busy_cnt = 0;
        while (!out_valid && edges < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        check("done_timeout", out_valid, 1);
    endtask

    task automatic result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eovf, input int elat);
        wait_done();
        check({tag, "_latency"}, edges, elat);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dz"}, dz, edz);
        check({tag, "_ovf"}, ovf, eovf);
        $display("op %s: q=%02h r=%02h dz=%0d ovf=%0d latency=%0d busy=%0d",
                 tag, q, r, dz, ovf, edges, busy_cnt);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        n         = 16'h0000;
        d         = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_q_r", {q, r}, 16'h0000);
        check("rst_dz_ovf", {dz, ovf}, 2'b00);
        rst_n = 1'b1;

        start(16'h1234, 8'h56);
        result("basic", 8'h36, 8'h10, 1'b0, 1'b0, 9);
        check("basic_busy_cycles", busy_cnt, 8);

        start(16'h00FF, 8'h01);
        result("div_by_one", 8'hFF, 8'h00, 1'b0, 1'b0, 9);
        check("div_by_one_busy_cycles", busy_cnt, 8);

        start(16'hABCD, 8'h00);
        result("div_zero", 8'hA5, 8'hCD, 1'b1, 1'b0, 1);
        check("div_zero_no_busy", busy_cnt, 0);

        start(16'h7FFF, 8'h80);
        result("max_q", 8'hFF, 8'h7F, 1'b0, 1'b0, 9);

        start(16'h0000, 8'h05);
        result("zero_n", 8'h00, 8'h00, 1'b0, 1'b0, 9);

`ifdef DIV_SEQ_OVF_CHK_EN
        start(16'h0100, 8'h01);
        result("ovf", 8'hFF, 8'hFF, 1'b0, 1'b1, 1);
`else
        start(16'h0100, 8'h01);
        result("ovf", 8'hFF, 8'h01, 1'b0, 1'b0, 9);
`endif

        // Consumer stalls while the requester keeps offering new operands.
        out_ready = 1'b0;
        start(16'h1234, 8'h56);
        result("stall", 8'h36, 8'h10, 1'b0, 1'b0, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            n        = 16'hFFFF;
            d        = 8'h03;
            @(posedge clk);
            #1;
            check("stall_hold", {out_valid, in_ready, q, r}, {2'b10, 8'h36, 8'h10});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", {out_valid, in_ready}, 2'b01);
        start(16'h0064, 8'h07);
        result("after_stall", 8'h0E, 8'h02, 1'b0, 1'b0, 9);

        // Abort mid-calculation with an asynchronous reset.
        start(16'h1234, 8'h56);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_state", {busy, out_valid, in_ready}, 3'b001);
        check("abort_q_r", {q, r}, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_result", out_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start(16'h0FA0, 8'h40);
        result("after_reset", 8'h3E, 8'h20, 1'b0, 1'b0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
